// File: rtl/sync_rst_gen_pkg.sv
// Shared types and sizing helpers for the staggered reset generator.
package sync_rst_gen_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    STRETCH,
    RELEASE,
    DONE
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchronizer: asserts asynchronously, deasserts after STAGES clock edges.
module rst_sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync
);

  if (STAGES < 2) begin : g_bad_stages
    $error("rst_sync_chain: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_sync = sync_q[STAGES-1];

endmodule

// File: rtl/sync_rst_gen.sv
// Root reset generator: filters a software reset request, stretches the reset
// and releases NUM_OUTS synchronous active-high resets in a staggered order.
module sync_rst_gen
  import sync_rst_gen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned NUM_OUTS       = 3,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned FILTER_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_rst_req,
  output logic [NUM_OUTS-1:0] rst_out,
  output logic                rst_done,
  output logic                busy
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sync_rst_gen: SYNC_STAGES must be at least 2");
  end
  if (STRETCH_CYCLES < 1) begin : g_bad_stretch
    $error("sync_rst_gen: STRETCH_CYCLES must be at least 1");
  end
  if (NUM_OUTS < 1) begin : g_bad_outs
    $error("sync_rst_gen: NUM_OUTS must be at least 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stagger
    $error("sync_rst_gen: STAGGER_CYCLES must be at least 1");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("sync_rst_gen: FILTER_CYCLES must be at least 1");
  end

  localparam int unsigned CW = cnt_width(STRETCH_CYCLES, STAGGER_CYCLES);
  localparam int unsigned IW = $clog2(NUM_OUTS + 1);
  localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_END      = IW'(NUM_OUTS);
  localparam logic [FW-1:0] FILT_MAX     = FW'(FILTER_CYCLES);

  logic                rst_sync;
  logic                qual;

  state_e              state_q,    state_d;
  logic [CW-1:0]       cnt_q,      cnt_d;
  logic [IW-1:0]       idx_q,      idx_d;
  logic [FW-1:0]       flt_q,      flt_d;
  logic                req_hold_q, req_hold_d;
  logic [NUM_OUTS-1:0] rst_out_q,  rst_out_d;
  logic                rst_done_q, rst_done_d;
  logic                busy_q,     busy_d;

  rst_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_sync (rst_sync)
  );

  always_comb begin
    flt_d = '0;
    if (sw_rst_req) begin
      flt_d = (flt_q == FILT_MAX) ? flt_q : flt_q + FW'(1);
    end
  end

  assign qual = (flt_q == FILT_MAX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    rst_done_d = rst_done_q;
    // Stretch is held at 0 through the edge where the request is seen to drop,
    // mirroring how rst_sync rising is first observed one edge later.
    req_hold_d = qual && (state_q != ASSERT);

    if (qual && (state_q != ASSERT)) begin
      state_d    = STRETCH;
      cnt_d      = '0;
      idx_d      = '0;
      rst_out_d  = '1;
      rst_done_d = 1'b0;
    end else begin
      case (state_q)
        ASSERT: begin
          if (rst_sync) begin
            state_d = STRETCH;
            cnt_d   = '0;
          end
        end
        STRETCH: begin
          if (req_hold_q) begin
            cnt_d = '0;
          end else if (cnt_q == STRETCH_LAST) begin
            state_d      = RELEASE;
            rst_out_d[0] = 1'b0;
            idx_d        = IW'(1);
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (idx_q == IDX_END) begin
            state_d    = DONE;
            rst_done_d = 1'b1;
          end else if (cnt_q == STAGGER_LAST) begin
            for (int unsigned i = 0; i < NUM_OUTS; i++) begin
              if (IW'(i) == idx_q) begin
                rst_out_d[i] = 1'b0;
              end
            end
            idx_d = idx_q + IW'(1);
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          rst_done_d = 1'b1;
        end
        default: begin
          state_d = ASSERT;
        end
      endcase
    end

    busy_d = |rst_out_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      flt_q      <= '0;
      req_hold_q <= 1'b0;
      rst_out_q  <= '1;
      rst_done_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      flt_q      <= flt_d;
      req_hold_q <= req_hold_d;
      rst_out_q  <= rst_out_d;
      rst_done_q <= rst_done_d;
      busy_q     <= busy_d;
    end
  end

  assign rst_out  = rst_out_q;
  assign rst_done = rst_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sync_rst_gen.sv
// Scoreboard bench for sync_rst_gen: default instance plus a minimal-parameter instance.
module tb_sync_rst_gen;

  localparam int N    = 3;
  localparam int STAG = 4;
  localparam int NEVER = 1 << 20;

  typedef struct packed {
    logic [2:0] ro;
    logic       done;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] rst_out;
  logic       rst_done;
  logic       busy;

  logic       rst2_n = 1'b0;
  logic       sw2 = 1'b0;
  logic [0:0] rst_out2;
  logic       rst_done2;
  logic       busy2;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       exp_q[$];
  logic [2:0] exp2_q[$];

  sync_rst_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .rst_done   (rst_done),
    .busy       (busy)
  );

  sync_rst_gen #(
    .SYNC_STAGES    (3),
    .STRETCH_CYCLES (1),
    .NUM_OUTS       (1),
    .STAGGER_CYCLES (1),
    .FILTER_CYCLES  (2)
  ) dut_min (
    .clk        (clk),
    .rst_n      (rst2_n),
    .sw_rst_req (sw2),
    .rst_out    (rst_out2),
    .rst_done   (rst_done2),
    .busy       (busy2)
  );

  always #5 clk = ~clk;

  // Expected outputs at edge e: idle before reassertion at a, bit k falls at f+STAG*k.
  function automatic exp_t model(input int e, input int a1, input int f1,
                                 input int a2, input int f2);
    int   a;
    int   f;
    exp_t x;
    if (a2 > 0 && e >= a2) begin
      a = a2; f = f2;
    end else begin
      a = a1; f = f1;
    end
    if (e < a) begin
      x.ro = 3'b000; x.done = 1'b1; x.busy = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) x.ro[k] = (e < f + STAG * k);
      x.done = (e >= f + STAG * (N - 1) + 1);
      x.busy = |x.ro;
    end
    return x;
  endfunction

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rst_out, rst_done, busy} !== 5'b111_0_1) begin
      n_fail++;
      $display("FAIL reset_default: got rst_out=%b done=%b busy=%b, expected 111 0 1",
               rst_out, rst_done, busy);
    end
    n_checks++;
    if ({rst_out2, rst_done2, busy2} !== 3'b1_0_1) begin
      n_fail++;
      $display("FAIL reset_min: got rst_out=%b done=%b busy=%b, expected 1 0 1",
               rst_out2, rst_done2, busy2);
    end
  endtask

  task automatic test_power_up;
    exp_t x;
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      sw_rst_req = 1'b0;
      exp_q.push_back(model(e, 0, 19, 0, 0));
      @(posedge clk); #1;
      x = exp_q.pop_front();
      n_checks++;
      if ({rst_out, rst_done, busy} !== {x.ro, x.done, x.busy}) begin
        n_fail++;
        $display("FAIL power_up edge %0d: got rst_out=%b done=%b busy=%b, expected %b %b %b",
                 e, rst_out, rst_done, busy, x.ro, x.done, x.busy);
      end
    end
  endtask

  task automatic test_glitch;
    exp_t x;
    for (int e = 1; e <= 6; e++) begin
      sw_rst_req = (e == 1);
      exp_q.push_back(model(e, NEVER, 0, 0, 0));
      @(posedge clk); #1;
      x = exp_q.pop_front();
      n_checks++;
      if ({rst_out, rst_done, busy} !== {x.ro, x.done, x.busy}) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got rst_out=%b done=%b busy=%b, expected %b %b %b",
                 e, rst_out, rst_done, busy, x.ro, x.done, x.busy);
      end
    end
  endtask

  task automatic test_request;
    exp_t x;
    // High samples at edges 1..5, first low sample at edge 6.
    for (int e = 1; e <= 36; e++) begin
      sw_rst_req = (e <= 5);
      exp_q.push_back(model(e, 3, 6 + 17, 0, 0));
      @(posedge clk); #1;
      x = exp_q.pop_front();
      n_checks++;
      if ({rst_out, rst_done, busy} !== {x.ro, x.done, x.busy}) begin
        n_fail++;
        $display("FAIL request edge %0d: got rst_out=%b done=%b busy=%b, expected %b %b %b",
                 e, rst_out, rst_done, busy, x.ro, x.done, x.busy);
      end
    end
  endtask

  task automatic test_mid_release;
    exp_t x;
    // Request at edges 1..2, then a second one at 21..22 while rst_out is 110.
    for (int e = 1; e <= 52; e++) begin
      sw_rst_req = (e <= 2) || (e == 21) || (e == 22);
      exp_q.push_back(model(e, 3, 3 + 17, 23, 23 + 17));
      @(posedge clk); #1;
      x = exp_q.pop_front();
      n_checks++;
      if ({rst_out, rst_done, busy} !== {x.ro, x.done, x.busy}) begin
        n_fail++;
        $display("FAIL mid_release edge %0d: got rst_out=%b done=%b busy=%b, expected %b %b %b",
                 e, rst_out, rst_done, busy, x.ro, x.done, x.busy);
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_async_reset;
    exp_t x;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rst_out, rst_done, busy} !== 5'b111_0_1) begin
      n_fail++;
      $display("FAIL async_in_done: got rst_out=%b done=%b busy=%b, expected 111 0 1",
               rst_out, rst_done, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // A request that qualifies while still in ASSERT must not disturb the sequence.
    for (int e = 1; e <= 10; e++) begin
      sw_rst_req = (e <= 2);
      exp_q.push_back(model(e, 0, 19, 0, 0));
      @(posedge clk); #1;
      x = exp_q.pop_front();
      n_checks++;
      if ({rst_out, rst_done, busy} !== {x.ro, x.done, x.busy}) begin
        n_fail++;
        $display("FAIL assert_req edge %0d: got rst_out=%b done=%b busy=%b, expected %b %b %b",
                 e, rst_out, rst_done, busy, x.ro, x.done, x.busy);
      end
    end
    sw_rst_req = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rst_out, rst_done, busy} !== 5'b111_0_1) begin
      n_fail++;
      $display("FAIL async_in_stretch: got rst_out=%b done=%b busy=%b, expected 111 0 1",
               rst_out, rst_done, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      exp_q.push_back(model(e, 0, 19, 0, 0));
      @(posedge clk); #1;
      x = exp_q.pop_front();
      n_checks++;
      if ({rst_out, rst_done, busy} !== {x.ro, x.done, x.busy}) begin
        n_fail++;
        $display("FAIL re_power_up edge %0d: got rst_out=%b done=%b busy=%b, expected %b %b %b",
                 e, rst_out, rst_done, busy, x.ro, x.done, x.busy);
      end
    end
  endtask

  task automatic test_param_sweep;
    logic [2:0] x;
    logic       ro0;
    rst2_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      ro0 = (e < 5);
      exp2_q.push_back({ro0, (e >= 6), ro0});
      @(posedge clk); #1;
      x = exp2_q.pop_front();
      n_checks++;
      if ({rst_out2, rst_done2, busy2} !== x) begin
        n_fail++;
        $display("FAIL param_sweep edge %0d: got rst_out=%b done=%b busy=%b, expected %b %b %b",
                 e, rst_out2, rst_done2, busy2, x[2], x[1], x[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_request();
    test_mid_release();
    test_async_reset();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
